// File: rtl/three_input_debouncer_pkg.sv
// Shared definitions for the three-input debouncer: per-channel FSM states
// and the default debounce length.
package three_input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/three_input_debouncer_debounce_channel.sv
// One debounce channel: two-flop synchronizer, debounce FSM with counter,
// registered level output and registered rising-edge pulse.
module debounce_channel
  import three_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             rise_next;

  // din is asynchronous; only sync1 may sample it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_LOW: begin
        if (sync2) begin
          state_next = S_WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync2) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_next = S_WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (sync2) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge the FSM commits, without a path from sync2 to the ports.
  always_comb begin
    level_next = (state_next == S_HIGH) || (state_next == S_WAIT_LOW);
    rise_next  = (state_next == S_HIGH) && (state == S_WAIT_HIGH);
  end

endmodule

// File: rtl/three_input_debouncer.sv
// Three independent debounce channels turning raw board inputs into clean
// levels a/b/c for the OR stage, plus per-channel press pulses.
module three_input_debouncer
  import three_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] rise
);

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_raw[0]),
    .level (a),
    .rise  (rise[0])
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_raw[1]),
    .level (b),
    .rise  (rise[1])
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_c (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_raw[2]),
    .level (c),
    .rise  (rise[2])
  );

endmodule

// File: tb/tb_three_input_debouncer.sv
// Bench for three_input_debouncer: a hand-computed vector table followed by
// model-scored corner sequences (glitch, bounce, reset mid-count).
module tb_three_input_debouncer;

  localparam int DC = 4;

  typedef struct {
    logic       rst;
    logic [2:0] btn;
    logic [2:0] exp_lvl;
    logic [2:0] exp_rise;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic       a, b, c;
  logic [2:0] rise;

  int checks   = 0;
  int failures = 0;

  vec_t       tbl[$];
  logic [5:0] sb_q[$];

  logic [2:0] m_s1, m_s2, m_stable, m_rise;
  int         m_run[3];

  logic [2:0] obs_lvl;
  logic [2:0] obs_rise;

  three_input_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .a       (a),
    .b       (b),
    .c       (c),
    .rise    (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count consecutive synchronized samples disagreeing with the
  // stable level; DC of them in a row flips the level.
  task automatic model_edge(input logic r, input logic [2:0] raw);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      m_rise = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_stable[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        if (m_run[i] == DC) begin
          m_stable[i] = ~m_stable[i];
          m_rise[i]   = m_stable[i];
          m_run[i]    = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic checkOutput(input string name);
    logic [5:0] exp;
    obs_lvl  = {c, b, a};
    obs_rise = rise;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got lvl=%b rise=%b", name, obs_lvl, obs_rise);
    end else begin
      exp = sb_q.pop_front();
      if ({obs_lvl, obs_rise} !== exp) begin
        failures++;
        $display("[TB] FAIL %s @%0t: got lvl=%b rise=%b, expected lvl=%b rise=%b",
                 name, $time, obs_lvl, obs_rise, exp[5:3], exp[2:0]);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] raw, input logic use_model,
                               input logic [5:0] exp_tbl, input string name);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    if (use_model) sb_q.push_back({m_stable, m_rise});
    else sb_q.push_back(exp_tbl);
    @(negedge clk);
    checkOutput(name);
  endtask

  task automatic step(input logic r, input logic [2:0] raw, input string name);
    applyStimulus(r, raw, 1'b1, 6'd0, name);
  endtask

  task automatic directed(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic add_vec(input logic r, input logic [2:0] bt, input logic [2:0] lv,
                         input logic [2:0] rs, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, bt, lv, rs});
  endtask

  initial begin
    int   rise_cnt;
    int   b_high;
    int   lat;
    logic done;

    rst     = 1'b1;
    btn_raw = 3'b000;

    add_vec(1'b1, 3'b111, 3'b000, 3'b000, 2);
    add_vec(1'b0, 3'b111, 3'b000, 3'b000, 5);
    add_vec(1'b0, 3'b111, 3'b111, 3'b111, 1);
    add_vec(1'b0, 3'b111, 3'b111, 3'b000, 2);
    add_vec(1'b0, 3'b110, 3'b111, 3'b000, 5);
    add_vec(1'b0, 3'b110, 3'b110, 3'b000, 2);
    add_vec(1'b0, 3'b111, 3'b110, 3'b000, 5);
    add_vec(1'b0, 3'b111, 3'b111, 3'b001, 1);
    add_vec(1'b0, 3'b111, 3'b111, 3'b000, 1);

    $display("[TB] table phase: %0d vectors", tbl.size());
    foreach (tbl[i])
      applyStimulus(tbl[i].rst, tbl[i].btn, 1'b0, {tbl[i].exp_lvl, tbl[i].exp_rise}, "table");

    step(1'b1, 3'b000, "reset");
    step(1'b1, 3'b000, "reset");
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, "idle");

    b_high = 0; rise_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b010, "glitch3");
      b_high += obs_lvl[1]; rise_cnt += obs_rise[1];
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b000, "glitch3_tail");
      b_high += obs_lvl[1]; rise_cnt += obs_rise[1];
    end
    directed("glitch3_b_high", b_high, 0);
    directed("glitch3_rise", rise_cnt, 0);

    rise_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b010, "glitch4");
      rise_cnt += obs_rise[1];
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b000, "glitch4_tail");
      rise_cnt += obs_rise[1];
    end
    directed("glitch4_rise", rise_cnt, 1);

    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, "idle");

    rise_cnt = 0;
    begin
      logic [4:0] pattern;
      pattern = 5'b10101;
      for (int i = 0; i < 5; i++) begin
        step(1'b0, {pattern[i], 2'b00}, "bounce");
        rise_cnt += obs_rise[2];
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b100, "bounce_hold");
      rise_cnt += obs_rise[2];
    end
    directed("bounce_rise_count", rise_cnt, 1);

    step(1'b0, 3'b000, "drop");
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, "idle");

    for (int i = 0; i < 4; i++) step(1'b0, 3'b111, "pre_reset_count");
    step(1'b1, 3'b111, "mid_reset");
    directed("mid_reset_levels", int'(obs_lvl), 0);
    lat = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b0, 3'b111, "post_reset");
      lat++;
      if (obs_lvl == 3'b111) done = 1'b1;
    end
    directed("post_reset_latency", done ? lat : -1, 6);
    directed("post_reset_rise", int'(obs_rise), 7);
    step(1'b0, 3'b111, "post_reset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
